// File: rtl/pkg_memory.sv
// Shared constants and types for the banked activation memory.
package pkg_memory;
   localparam int ACT_BANK_NUM = 4;
   localparam int ACT_DATA_W   = 32;
   localparam int ACT_DEPTH    = 504;
   localparam int ACT_RD_LAT   = 2;

   typedef enum logic {ACT_IDLE, ACT_CLEAR} act_state_e;
   typedef logic [$clog2(ACT_BANK_NUM)-1:0] act_bank_t;
endpackage

// File: rtl/act_bank_ram.sv
// One simple-dual-port activation bank: synchronous read-first port followed
// by RD_LAT-1 output registers, so data appears RD_LAT cycles after i_re.
module act_bank_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 504,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 2
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem  [DEPTH];
   logic [DATA_W-1:0] r_rd_p [RD_LAT];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Reading in a separate process keeps old data on a same-address collision.
   always_ff @(posedge clk) begin
      if (i_re) r_rd_p[0] <= r_mem[i_raddr];
      for (int i = 1; i < RD_LAT; i++) r_rd_p[i] <= r_rd_p[i-1];
   end

   assign o_rdata = r_rd_p[RD_LAT-1];
endmodule

// File: rtl/act_bank_ctrl.sv
// Banked activation memory controller: ping-pong rd/wr bank selection,
// zero-fill FSM, pipelined bank-tagged reads and a sticky address error.
module act_bank_ctrl
   import pkg_memory::*;
#(
   parameter int NUM_BANKS = ACT_BANK_NUM,
   parameter int DATA_W    = ACT_DATA_W,
   parameter int DEPTH     = ACT_DEPTH,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int RD_LAT    = ACT_RD_LAT
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_valid,
   input  logic [$clog2(NUM_BANKS)-1:0] cfg_rd_bank,
   input  logic [$clog2(NUM_BANKS)-1:0] cfg_wr_bank,
   input  logic                         swap,
   input  logic                         clr_start,
   output logic                         busy,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic                         addr_err,
   input  logic                         err_clr
);
   localparam int                BANK_W   = $clog2(NUM_BANKS);
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   act_state_e        r_state, w_state_nxt;
   logic [BANK_W-1:0] r_rd_bank, r_wr_bank;
   logic [ADDR_W-1:0] r_clr_addr;
   logic              r_addr_err;
   logic [RD_LAT-1:0] r_vld_p;
   logic [BANK_W-1:0] r_sel_p [RD_LAT];
   logic [RD_LAT-1:0] r_oob_p;
   logic [DATA_W-1:0] r_rd_hold;

   logic              w_idle, w_rd_oob, w_wr_oob, w_cfg_bad, w_err_now, w_wr_acc;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_dout [NUM_BANKS];
   logic [DATA_W-1:0] w_rd_mux;

   assign w_idle    = (r_state == ACT_IDLE);
   assign w_rd_oob  = ({1'b0, rd_addr} >= LP_DEPTH);
   assign w_wr_oob  = ({1'b0, wr_addr} >= LP_DEPTH);
   assign w_cfg_bad = (int'(cfg_rd_bank) >= NUM_BANKS) || (int'(cfg_wr_bank) >= NUM_BANKS);
   assign w_err_now = (rd_en && w_rd_oob) || (wr_en && w_wr_oob) ||
                      (cfg_valid && w_idle && w_cfg_bad);
   assign w_wr_acc  = wr_en && w_idle && !w_wr_oob;

   // The clear sequencer owns the write port of the write bank while busy.
   assign w_ram_we    = !w_idle || w_wr_acc;
   assign w_ram_waddr = w_idle ? wr_addr : r_clr_addr;
   assign w_ram_wdata = w_idle ? wr_data : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACT_IDLE:  if (clr_start) w_state_nxt = ACT_CLEAR;
         ACT_CLEAR: if (r_clr_addr == LP_LAST) w_state_nxt = ACT_IDLE;
         default:   w_state_nxt = ACT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ACT_IDLE;
         r_clr_addr <= '0;
         r_rd_bank  <= '0;
         r_wr_bank  <= BANK_W'(1);
         r_addr_err <= 1'b0;
         r_vld_p    <= '0;
         r_rd_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_idle) r_clr_addr <= '0;
         else        r_clr_addr <= r_clr_addr + 1'b1;

         // A config load in the same cycle as swap takes priority.
         if (w_idle && cfg_valid) begin
            if (!w_cfg_bad) begin
               r_rd_bank <= cfg_rd_bank;
               r_wr_bank <= cfg_wr_bank;
            end
         end else if (w_idle && swap) begin
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= r_rd_bank;
         end

         if (w_err_now)    r_addr_err <= 1'b1;
         else if (err_clr) r_addr_err <= 1'b0;

         r_vld_p[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
         if (rd_valid) r_rd_hold <= w_rd_mux;
      end
   end

   // Bank tag and range flag ride with each read so a later swap cannot redirect it.
   always_ff @(posedge clk) begin
      r_sel_p[0] <= r_rd_bank;
      r_oob_p[0] <= w_rd_oob;
      for (int i = 1; i < RD_LAT; i++) begin
         r_sel_p[i] <= r_sel_p[i-1];
         r_oob_p[i] <= r_oob_p[i-1];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      act_bank_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W),
         .RD_LAT (RD_LAT)
      ) u_ram (
         .clk     (clk),
         .i_we    (w_ram_we && (r_wr_bank == BANK_W'(b))),
         .i_waddr (w_ram_waddr),
         .i_wdata (w_ram_wdata),
         .i_re    (rd_en && !w_rd_oob && (r_rd_bank == BANK_W'(b))),
         .i_raddr (rd_addr),
         .o_rdata (w_ram_dout[b])
      );
   end

   assign w_rd_mux = r_oob_p[RD_LAT-1] ? '0 : w_ram_dout[r_sel_p[RD_LAT-1]];
   assign rd_valid = r_vld_p[RD_LAT-1];
   assign rd_data  = rd_valid ? w_rd_mux : r_rd_hold;
   assign busy     = !w_idle;
   assign wr_ready = w_idle;
   assign addr_err = r_addr_err;
endmodule

// File: tb/tb_act_bank_ctrl.sv
// Self-checking bench for act_bank_ctrl: directed scenarios plus a randomized
// run against an array/queue reference model of the activation memory.
module tb_act_bank_ctrl;
   localparam int NB     = 4;
   localparam int DW     = 32;
   localparam int DEPTH  = 504;
   localparam int AW     = 9;
   localparam int RD_LAT = 2;

   logic          clk;
   logic          rst_n;
   logic          cfg_valid;
   logic [1:0]    cfg_rd_bank, cfg_wr_bank;
   logic          swap, clr_start, busy;
   logic          rd_en, rd_valid;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] rd_data, wr_data;
   logic          wr_en, wr_ready, addr_err, err_clr;

   act_bank_ctrl #(
      .NUM_BANKS (NB), .DATA_W (DW), .DEPTH (DEPTH), .ADDR_W (AW), .RD_LAT (RD_LAT)
   ) dut (
      .clk (clk), .rst_n (rst_n), .cfg_valid (cfg_valid),
      .cfg_rd_bank (cfg_rd_bank), .cfg_wr_bank (cfg_wr_bank),
      .swap (swap), .clr_start (clr_start), .busy (busy),
      .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data), .rd_valid (rd_valid),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ready (wr_ready),
      .addr_err (addr_err), .err_clr (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   logic [DW-1:0] m_mem [NB][DEPTH];
   int            m_rd, m_wr, m_left;
   logic          m_err;
   logic [DW-1:0] q_data [$];
   int            q_due  [$];
   logic          exp_vld;
   logic [DW-1:0] exp_data;

   task automatic m_reset();
      m_rd = 0; m_wr = 1; m_left = 0; m_err = 1'b0;
      q_data.delete(); q_due.delete();
      exp_vld = 1'b0; exp_data = '0;
   endtask

   task automatic idle_inputs();
      cfg_valid = 0; cfg_rd_bank = 0; cfg_wr_bank = 0; swap = 0; clr_start = 0;
      rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; err_clr = 0;
   endtask

   // Apply one clock edge to the model using the current inputs, then to the DUT.
   task automatic step();
      int  n;
      bit  idle;
      int  t;
      n    = cyc + 1;
      idle = (m_left == 0);
      if (rd_en) begin
         q_data.push_back((int'(rd_addr) < DEPTH) ? m_mem[m_rd][rd_addr] : '0);
         q_due.push_back(n + RD_LAT - 1);
      end
      if ((rd_en && int'(rd_addr) >= DEPTH) || (wr_en && int'(wr_addr) >= DEPTH) ||
          (cfg_valid && idle && (int'(cfg_rd_bank) >= NB || int'(cfg_wr_bank) >= NB)))
         m_err = 1'b1;
      else if (err_clr)
         m_err = 1'b0;
      if (idle && wr_en && int'(wr_addr) < DEPTH) m_mem[m_wr][wr_addr] = wr_data;
      if (!idle) begin
         m_mem[m_wr][DEPTH - m_left] = '0;
         m_left--;
      end else if (clr_start) begin
         m_left = DEPTH;
      end
      if (idle && cfg_valid) begin
         if (int'(cfg_rd_bank) < NB && int'(cfg_wr_bank) < NB) begin
            m_rd = int'(cfg_rd_bank); m_wr = int'(cfg_wr_bank);
         end
      end else if (idle && swap) begin
         t = m_rd; m_rd = m_wr; m_wr = t;
      end
      @(posedge clk); #1;
      cyc = n;
      exp_vld = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         exp_vld  = 1'b1;
         exp_data = q_data.pop_front();
         void'(q_due.pop_front());
      end
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (busy === 1'b1 && g < 1000) begin step(); g++; end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, g);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      m_reset();
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
      checks++; if (rd_data !== '0)    begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %0b want 0", addr_err); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_swap_read();
      wr_en = 1; wr_addr = 5; wr_data = 32'hA5A5_0001; step(); wr_en = 0;
      swap = 1; step(); swap = 0;
      rd_en = 1; rd_addr = 5; step(); rd_en = 0;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early: rd_valid=%0b want 0", rd_valid); end
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001) begin
         errors++; $display("FAIL swap_read: valid=%0b data=%h want 1/a5a50001", rd_valid, rd_data);
      end
      step();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'hA5A5_0001) begin
         errors++; $display("FAIL rd_hold: valid=%0b data=%h want 0/a5a50001", rd_valid, rd_data);
      end
   endtask

   task automatic test_clear();
      int cnt, bad, got, nz;
      cnt = 0; bad = 0; got = 0; nz = 0;
      swap = 1; step(); swap = 0;
      clr_start = 1; step(); clr_start = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         if (wr_ready !== 1'b0) bad++;
         cnt++;
         clr_start = (cnt == 10);
         step();
      end
      clr_start = 0;
      checks++; if (cnt != DEPTH) begin errors++; $display("FAIL clear_busy_len: got %0d want %0d", cnt, DEPTH); end
      checks++; if (bad != 0)     begin errors++; $display("FAIL clear_wr_ready: %0d cycles ready, want 0", bad); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_after: got %0b want 1", wr_ready); end
      swap = 1; step(); swap = 0;
      for (int a = 0; a < DEPTH + RD_LAT; a++) begin
         rd_en = (a < DEPTH); rd_addr = AW'(a % DEPTH);
         step();
         if (rd_valid === 1'b1) begin got++; if (rd_data !== '0) nz++; end
      end
      rd_en = 0;
      checks++; if (got != DEPTH) begin errors++; $display("FAIL clear_read_count: got %0d want %0d", got, DEPTH); end
      checks++; if (nz != 0)      begin errors++; $display("FAIL clear_read_zero: %0d nonzero words, want 0", nz); end
   endtask

   task automatic init_banks();
      int bl [3];
      bl = '{0, 2, 3};
      foreach (bl[i]) begin
         cfg_valid = 1; cfg_rd_bank = 2'd1; cfg_wr_bank = 2'(bl[i]); step(); cfg_valid = 0;
         clr_start = 1; step(); clr_start = 0;
         wait_idle();
      end
   endtask

   task automatic test_burst_during_clear();
      int first, last, got, bad;
      first = -1; last = -1; got = 0; bad = 0;
      cfg_valid = 1; cfg_rd_bank = 2'd1; cfg_wr_bank = 2'd0; step(); cfg_valid = 0;
      for (int i = 0; i < 10; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = 32'hC0DE_0000 + DW'(i); step();
      end
      wr_en = 0;
      cfg_valid = 1; cfg_rd_bank = 2'd0; cfg_wr_bank = 2'd2; step(); cfg_valid = 0;
      clr_start = 1; step(); clr_start = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy_start: got %0b want 1", busy); end
      for (int k = 0; k < 10 + RD_LAT + 2; k++) begin
         rd_en = (k < 10); rd_addr = AW'(k % 10);
         step();
         if (rd_valid === 1'b1) begin
            if (rd_data !== 32'hC0DE_0000 + DW'(got)) bad++;
            if (first < 0) first = k;
            last = k; got++;
         end
      end
      rd_en = 0;
      checks++; if (got != 10)         begin errors++; $display("FAIL burst_count: got %0d want 10", got); end
      checks++; if (bad != 0)          begin errors++; $display("FAIL burst_order: %0d wrong words, want 0", bad); end
      checks++; if (last - first != 9) begin errors++; $display("FAIL burst_bubbles: span %0d want 9", last - first); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL burst_busy_mid: got %0b want 1", busy); end
      wait_idle();
   endtask

   task automatic test_addr_err();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %0b want 0", addr_err); end
      wr_en = 1; wr_addr = AW'(DEPTH); wr_data = 32'hDEAD_BEEF; step(); wr_en = 0;
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_bad_write: got %0b want 1", addr_err); end
      err_clr = 1; step(); err_clr = 0;
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", addr_err); end
      err_clr = 1; rd_en = 1; rd_addr = AW'(510); step(); err_clr = 0; rd_en = 0;
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_clr_vs_new: got %0b want 1", addr_err); end
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         errors++; $display("FAIL err_bad_read: valid=%0b data=%h want 1/0", rd_valid, rd_data);
      end
      err_clr = 1; step(); err_clr = 0;
   endtask

   task automatic test_same_bank();
      cfg_valid = 1; cfg_rd_bank = 2'd2; cfg_wr_bank = 2'd2; step(); cfg_valid = 0;
      wr_en = 1; wr_addr = 7; wr_data = 32'h1; step();
      rd_en = 1; rd_addr = 7; wr_data = 32'h2; step();
      rd_en = 0; wr_en = 0; step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h1) begin
         errors++; $display("FAIL same_bank_old: valid=%0b data=%h want 1/1", rd_valid, rd_data);
      end
      rd_en = 1; rd_addr = 7; step(); rd_en = 0; step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin
         errors++; $display("FAIL same_bank_new: valid=%0b data=%h want 1/2", rd_valid, rd_data);
      end
   endtask

   task automatic test_reset_mid_clear();
      int got, lo_bad, hi_bad;
      got = 0; lo_bad = 0; hi_bad = 0;
      cfg_valid = 1; cfg_rd_bank = 2'd0; cfg_wr_bank = 2'd1; step(); cfg_valid = 0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = 32'h6000_0000 + DW'(i); step();
      end
      wr_en = 0;
      clr_start = 1; step(); clr_start = 0;
      repeat (100) step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy_before: got %0b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midclr_busy: got %0b want 0", busy); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready: got %0b want 1", wr_ready); end
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      swap = 1; step(); swap = 0;
      for (int a = 0; a < DEPTH + RD_LAT; a++) begin
         rd_en = (a < DEPTH); rd_addr = AW'(a % DEPTH);
         step();
         if (rd_valid === 1'b1) begin
            if (got < 100) begin if (rd_data !== '0) lo_bad++; end
            else if (rd_data !== 32'h6000_0000 + DW'(got)) hi_bad++;
            got++;
         end
      end
      rd_en = 0;
      checks++; if (got != DEPTH) begin errors++; $display("FAIL midclr_count: got %0d want %0d", got, DEPTH); end
      checks++; if (lo_bad != 0)  begin errors++; $display("FAIL midclr_cleared: %0d words not zero", lo_bad); end
      checks++; if (hi_bad != 0)  begin errors++; $display("FAIL midclr_untouched: %0d words changed", hi_bad); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 39) == 0) ? AW'($urandom_range(DEPTH, 511)) : AW'($urandom_range(0, DEPTH-1));
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = ($urandom_range(0, 39) == 0) ? AW'($urandom_range(DEPTH, 511)) : AW'($urandom_range(0, DEPTH-1));
         wr_data = $urandom;
         swap        = ($urandom_range(0, 29) == 0);
         cfg_valid   = ($urandom_range(0, 49) == 0);
         cfg_rd_bank = 2'($urandom_range(0, NB-1));
         cfg_wr_bank = 2'($urandom_range(0, NB-1));
         err_clr     = ($urandom_range(0, 19) == 0);
         clr_start   = ($urandom_range(0, 499) == 0);
         step();
         checks++;
         if (rd_valid !== exp_vld || rd_data !== exp_data) begin
            errors++; $display("FAIL rand_read c=%0d: valid=%0b data=%h want %0b/%h", c, rd_valid, rd_data, exp_vld, exp_data);
         end
         checks++;
         if (busy !== (m_left > 0) || wr_ready !== (m_left == 0)) begin
            errors++; $display("FAIL rand_ctrl c=%0d: busy=%0b ready=%0b want %0b/%0b", c, busy, wr_ready, m_left > 0, m_left == 0);
         end
         checks++;
         if (addr_err !== m_err) begin
            errors++; $display("FAIL rand_err c=%0d: addr_err=%0b want %0b", c, addr_err, m_err);
         end
      end
      idle_inputs();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_write_swap_read();
      test_clear();
      init_banks();
      test_burst_during_clear();
      test_addr_err();
      test_same_bank();
      test_reset_mid_clear();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
